pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/cpu_pipe_pkg.sv | 12 +
 rtl/hazard_mul_timer.sv | 33 +++
 rtl/pipeline_hazard_controller.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control types: hazard FSM states and the register-address width default.
package cpu_pipe_pkg;

    localparam int REG_ADDR_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        HALTED   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_mul_timer.sv
// Multiply stall countdown: loaded at multiply start, counts down to zero, flags the final stall cycle.
module hazard_mul_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rest)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle multiply stall and halt.
// Define HAZARD_PERF_CNT_EN to add saturating Stall_Count / Flush_Count performance counters.
module pipeline_hazard_controller
    import cpu_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  EX_MemRead,
    input  logic                  EX_RegWrite,
    input  logic [REG_ADDR_W-1:0] EX_Rd,
    input  logic                  EX_MulStart,
    input  logic                  EX_BranchTaken,
    input  logic                  ID_Halt,
    output logic                  PC_Write,
    output logic                  IFID_Freze,
    output logic                  IFID_Flush,
    output logic                  IDEX_Freze,
    output logic                  IDEX_Flush,
    output logic                  Mul_Done,
    output logic                  Halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]           Stall_Count,
    output logic [15:0]           Flush_Count
`endif
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    hz_state_e state_q, state_d;
    logic      mul_load, mul_busy, mul_last;
    logic      load_use;

    assign load_use = EX_MemRead & EX_RegWrite &
                      ((ID_UsesRs & (ID_Rs == EX_Rd)) | (ID_UsesRt & (ID_Rt == EX_Rd)));

    hazard_mul_timer #(.CNT_W(CNT_W)) u_mul_timer (
        .clk        (clk),
        .rest       (rest),
        .load_i     (mul_load),
        .load_val_i (MUL_LOAD),
        .busy_o     (mul_busy),
        .last_o     (mul_last)
    );

    always_comb begin
        state_d    = state_q;
        mul_load   = 1'b0;
        PC_Write   = 1'b1;
        IFID_Freze = 1'b0;
        IFID_Flush = 1'b0;
        IDEX_Freze = 1'b0;
        IDEX_Flush = 1'b0;
        Mul_Done   = 1'b0;
        Halted     = 1'b0;
        if (!rest) begin
            unique case (state_q)
                RUN: begin
                    // Priority: branch flush, then multiply stall, then load-use bubble.
                    if (EX_BranchTaken) begin
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (EX_MulStart) begin
                        PC_Write   = 1'b0;
                        IFID_Freze = 1'b1;
                        IDEX_Freze = 1'b1;
                        mul_load   = 1'b1;
                        state_d    = MUL_BUSY;
                    end else if (load_use) begin
                        PC_Write   = 1'b0;
                        IFID_Freze = 1'b1;
                        IDEX_Flush = 1'b1;
                    end
                    if (ID_Halt && !EX_BranchTaken && !EX_MulStart)
                        state_d = HALTED;
                end
                MUL_BUSY: begin
                    PC_Write   = 1'b0;
                    IFID_Freze = 1'b1;
                    IDEX_Freze = 1'b1;
                    if (mul_last || !mul_busy) begin
                        Mul_Done = mul_last;
                        state_d  = RUN;
                    end
                end
                HALTED: begin
                    PC_Write   = 1'b0;
                    IFID_Freze = 1'b1;
                    IDEX_Flush = 1'b1;
                    Halted     = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rest)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF))
            return v + 16'd1;
        return v;
    endfunction

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, !PC_Write && (state_q != HALTED));
        flush_cnt_d = sat_inc(flush_cnt_q, IFID_Flush);
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MUL_CYCLES=4); adds counter checks when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rest;
    logic [2:0] ID_Rs, ID_Rt, EX_Rd;
    logic       ID_UsesRs, ID_UsesRt, EX_MemRead, EX_RegWrite;
    logic       EX_MulStart, EX_BranchTaken, ID_Halt;
    logic       PC_Write, IFID_Freze, IFID_Flush, IDEX_Freze, IDEX_Flush, Mul_Done, Halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] Stall_Count, Flush_Count;
`endif

    int checks   = 0;
    int failures = 0;

    // {PC_Write, IFID_Freze, IFID_Flush, IDEX_Freze, IDEX_Flush, Mul_Done, Halted}
    logic [6:0] ctl;
    assign ctl = {PC_Write, IFID_Freze, IFID_Flush, IDEX_Freze, IDEX_Flush, Mul_Done, Halted};

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_ADDR_W(3), .MUL_CYCLES(4)) dut (
        .clk            (clk),
        .rest           (rest),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRs      (ID_UsesRs),
        .ID_UsesRt      (ID_UsesRt),
        .EX_MemRead     (EX_MemRead),
        .EX_RegWrite    (EX_RegWrite),
        .EX_Rd          (EX_Rd),
        .EX_MulStart    (EX_MulStart),
        .EX_BranchTaken (EX_BranchTaken),
        .ID_Halt        (ID_Halt),
        .PC_Write       (PC_Write),
        .IFID_Freze     (IFID_Freze),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Freze     (IDEX_Freze),
        .IDEX_Flush     (IDEX_Flush),
        .Mul_Done       (Mul_Done),
        .Halted         (Halted)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
`endif
    );

    task automatic clr();
        ID_Rs = 3'd0; ID_Rt = 3'd0; EX_Rd = 3'd0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
        EX_MulStart = 1'b0; EX_BranchTaken = 1'b0; ID_Halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic load_use_r3();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 3'd3;
        ID_Rs = 3'd3; ID_UsesRs = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        checks++;
        assert (ctl === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, ctl, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stimulus legality and structural invariants, watched every cycle.
    always @(negedge clk) begin
        if (!rest && EX_MulStart && EX_BranchTaken) begin
            failures++;
            $error("FAIL mul_branch_excl observed=11 expected=not both");
        end
        if ((IFID_Freze && IFID_Flush) || (IDEX_Freze && IDEX_Flush)) begin
            failures++;
            $error("FAIL freeze_flush_excl observed=%b expected=no freeze+flush pair", ctl);
        end
    end

    initial begin
        rest = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        load_use_r3();
        EX_BranchTaken = 1'b1;
        #1 chk("reset_outputs", 7'b1000000);

        tick(); rest = 1'b0;
        #1 chk("idle_after_reset", 7'b1000000);

`ifdef HAZARD_PERF_CNT_EN
        for (int i = 0; i < 3; i++) begin
            tick(); load_use_r3();
            #1 chk("perf_lu", 7'b0100100);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); EX_BranchTaken = 1'b1;
            #1 chk("perf_br", 7'b1010100);
        end
        tick();
        #1 chk16("stall_count", Stall_Count, 16'd3);
        chk16("flush_count", Flush_Count, 16'd2);
        force dut.stall_cnt_q = 16'hFFFF;
        force dut.flush_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        release dut.flush_cnt_q;
        tick(); load_use_r3();
        #1 chk("perf_sat_lu", 7'b0100100);
        tick(); EX_BranchTaken = 1'b1;
        #1 chk("perf_sat_br", 7'b1010100);
        tick();
        #1 chk16("stall_sat", Stall_Count, 16'hFFFF);
        chk16("flush_sat", Flush_Count, 16'hFFFF);
        tick(); rest = 1'b1;
        tick(); rest = 1'b0;
        #1 chk16("stall_clr", Stall_Count, 16'd0);
        chk16("flush_clr", Flush_Count, 16'd0);
`endif

        // Load-use on Rs, then released
        tick(); load_use_r3();
        #1 chk("lu_rs", 7'b0100100);
        tick();
        #1 chk("lu_clear", 7'b1000000);

        // Load-use on Rt
        tick(); EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 3'd5; ID_Rt = 3'd5; ID_UsesRt = 1'b1;
        #1 chk("lu_rt", 7'b0100100);

        // Matching register but not read: no stall
        tick(); EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 3'd3; ID_Rs = 3'd3;
        #1 chk("lu_unused_rs", 7'b1000000);

        // Load without register write: no stall
        tick(); load_use_r3(); EX_RegWrite = 1'b0;
        #1 chk("lu_no_regwrite", 7'b1000000);

        // Different register: no stall
        tick(); load_use_r3(); EX_Rd = 3'd4;
        #1 chk("lu_diff_reg", 7'b1000000);

        // Branch alone and branch beating load-use
        tick(); EX_BranchTaken = 1'b1;
        #1 chk("branch", 7'b1010100);
        tick(); load_use_r3(); EX_BranchTaken = 1'b1;
        #1 chk("branch_over_lu", 7'b1010100);

        // Multiply: four stall cycles, branch and load-use ignored while busy
        tick(); EX_MulStart = 1'b1;
        #1 chk("mul_c1", 7'b0101000);
        tick(); EX_BranchTaken = 1'b1;
        #1 chk("mul_c2_branch_ignored", 7'b0101000);
        tick(); load_use_r3();
        #1 chk("mul_c3_lu_ignored", 7'b0101000);
        tick();
        #1 chk("mul_c4_done", 7'b0101010);
        tick();
        #1 chk("mul_back_to_run", 7'b1000000);

        // Multiply beats load-use; reset in second busy cycle aborts it
        tick(); EX_MulStart = 1'b1; load_use_r3();
        #1 chk("mul_over_lu", 7'b0101000);
        tick();
        #1 chk("mul_busy1", 7'b0101000);
        tick(); rest = 1'b1;
        #1 chk("mul_busy2_rest", 7'b1000000);
        tick(); rest = 1'b0;
        #1 chk("mul_abort_run", 7'b1000000);
        tick();
        #1 chk("mul_abort_no_done", 7'b1000000);

        // Halt together with a branch does not halt
        tick(); ID_Halt = 1'b1; EX_BranchTaken = 1'b1;
        #1 chk("halt_with_branch", 7'b1010100);
        tick();
        #1 chk("halt_with_branch_next", 7'b1000000);

        // Halt: detection cycle is normal, then held until reset
        tick(); ID_Halt = 1'b1;
        #1 chk("halt_detect", 7'b1000000);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 7) EX_MulStart = 1'b1;
            if (i == 11) load_use_r3();
            #1 chk("halted_hold", 7'b0100101);
        end
        tick(); rest = 1'b1;
        #1 chk("halted_rest", 7'b1000000);
        tick(); rest = 1'b0;
        #1 chk("halt_cleared", 7'b1000000);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
